sc_apc_accum: RTL
=================

Name: sc_apc_accum

Overview:
Accumulating parallel counter stage that sits directly downstream of the stochastic-computing full adder. Each cycle it takes the adder's sum (weight 1) and cout (weight 2) bits and accumulates them into a binary count. Accumulation runs over a fixed stream length, converting the SC bitstream result back to binary. The finished count is presented on a valid/ready output handshake to the CGRA datapath.

Parameters:
STREAM_LEN, 256, number of accepted input samples per conversion; must be >= 1.
OUT_W, 10, width of out_count; must satisfy 2^OUT_W > 3*STREAM_LEN.
LEN_W (localparam), $clog2(STREAM_LEN+1), width of the internal sample counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  pulse that begins a conversion; honoured only in IDLE, or in DONE together with out_ready.
in_valid  input  1  fa_sum/fa_cout hold a valid sample this cycle.
fa_sum  input  1  full-adder sum bit, weight 1.
fa_cout  input  1  full-adder carry bit, weight 2.
out_valid  output  1  out_count holds a finished result.
out_ready  input  1  downstream accepts the result.
out_count  output  OUT_W  accumulated count, range 0..3*STREAM_LEN.
busy  output  1  high in ACCUM.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, accumulator=0, sample counter=0, out_valid=0, out_count=0, busy=0.
- Reset mid-conversion or mid-DONE aborts the conversion immediately. The partial result is discarded and out_valid is never raised for it.
- IDLE:
  - start=1 -> ACCUM; accumulator and sample counter cleared to 0.
  - in_valid is ignored in IDLE, including the start cycle itself. The first sample is taken the cycle after start.
- ACCUM:
  - On each cycle with in_valid=1: accumulator += fa_sum + 2*fa_cout (increment 0..3, zero-extended to OUT_W); sample counter += 1.
  - Cycles with in_valid=0 leave all state unchanged; gaps are unlimited.
  - start is ignored in ACCUM.
  - When the accepted sample is number STREAM_LEN -> DONE. On that same edge, out_count is loaded with the final sum including that sample.
  - out_valid=1 and busy=0 are registered, so they take effect the cycle after the last sample.
- DONE:
  - out_valid=1 and out_count hold stable until out_ready=1.
  - out_ready=1, start=0 -> IDLE; out_valid drops next cycle.
  - out_ready=1, start=1 -> ACCUM (back-to-back conversion); accumulator and counter cleared, out_valid drops next cycle.
  - start without out_ready is ignored.
  - in_valid is ignored in DONE; samples offered there are not counted.
- Latency: out_valid rises exactly 1 cycle after the edge accepting sample STREAM_LEN.
- out_count retains the last result after the handshake until the next DONE load or rst.
- Arithmetic never overflows, given the OUT_W constraint. Synthesis/elaboration shall fail via generate-time check if 2^OUT_W <= 3*STREAM_LEN.
- Minimum conversion time is STREAM_LEN+1 cycles from start to out_valid.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Full-scale: STREAM_LEN=256, start, 256 cycles in_valid=1, fa_sum=1, fa_cout=1 -> out_valid 1 cycle after the last sample, out_count=768; busy low from that cycle.
2. Zero and mixed: all-zero stream -> out_count=0. Alternating (sum=1,cout=0)/(sum=0,cout=1) for 256 samples -> out_count=384.
3. Gaps: random in_valid=0 bubbles (~50%), all samples sum=1, cout=0 -> out_count=256 exactly. Samples offered in IDLE/DONE are not counted; start during ACCUM has no effect.
4. Backpressure: hold out_ready=0 for 20 cycles after DONE -> out_valid and out_count stable throughout. out_ready=1 -> out_valid=0 the next cycle.
5. Back-to-back: out_ready=1 and start=1 in the same DONE cycle -> a new conversion starts without passing through IDLE. The second result (e.g. 256 samples of cout=1 -> 512) is correct and independent of the first.
6. Reset mid-op: rst=1 after 100 samples -> next cycle all outputs 0, state IDLE. A fresh start plus 256 samples of sum=1 -> out_count=256 with no residue.

Source files
------------

// File: rtl/sc_apc_accum_if.sv
// Handshake bundle between the SC full adder, the accumulating parallel counter and the CGRA datapath.
// master drives the samples and controls; slave is the counter.
interface sc_apc_accum_if #(
  parameter int OUT_W = 10
);
  logic             start;
  logic             in_valid;
  logic             fa_sum;
  logic             fa_cout;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_count;
  logic             busy;

  modport master (
    output start, in_valid, fa_sum, fa_cout, out_ready,
    input  out_valid, out_count, busy
  );

  modport slave (
    input  start, in_valid, fa_sum, fa_cout, out_ready,
    output out_valid, out_count, busy
  );
endinterface

// File: rtl/sc_apc_accum.sv
// Accumulating parallel counter: sums full-adder sum (x1) and cout (x2) bits over STREAM_LEN
// accepted samples and offers the binary count on a valid/ready handshake.
module sc_apc_accum #(
  parameter int STREAM_LEN = 256,
  parameter int OUT_W      = 10
) (
  input logic           clk,
  input logic           rst,
  sc_apc_accum_if.slave bus
);
  localparam int LEN_W = $clog2(STREAM_LEN + 1);
  localparam logic [LEN_W-1:0] LAST = LEN_W'(STREAM_LEN - 1);

  // The maximum count 3*STREAM_LEN must fit in OUT_W bits.
  generate
    if (STREAM_LEN < 1 || (64'd1 << OUT_W) <= 64'(3 * STREAM_LEN)) begin : g_bad_params
      $error("sc_apc_accum: need STREAM_LEN >= 1 and 2**OUT_W > 3*STREAM_LEN");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_nxt;
  logic [OUT_W-1:0] inc;
  logic [LEN_W-1:0] cnt;
  logic [OUT_W-1:0] out_count_q;
  logic             out_valid_q;
  logic             busy_q;

  assign inc     = OUT_W'({bus.fa_cout, bus.fa_sum});
  assign acc_nxt = acc + inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= ACCUM;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (bus.in_valid) begin
            acc <= acc_nxt;
            cnt <= cnt + LEN_W'(1);
            // Final sample: the result published includes this sample's weight.
            if (cnt == LAST) begin
              state       <= DONE;
              out_count_q <= acc_nxt;
              out_valid_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.start) begin
              state  <= ACCUM;
              acc    <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.busy      = busy_q;
endmodule
